// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline control unit.
// Arbitrates stall requests from id, ex and mem into the 6-bit stall vector,
// owns the ex multi-cycle stall counter and issues a one-cycle flush with a
// redirect PC when cp0 commits an exception or eret.
module pipe_ctrl #(
  parameter logic [31:0] EXCP_VEC = 32'h0000_0380,
  parameter int          CNT_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_stall_req,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             mem_stall_req,
  input  logic             excp_valid,
  input  logic             excp_eret,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mc_busy,
  output logic             mc_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [31:0]        new_pc_q;
  logic [31:0]        new_pc_d;
  logic               ex_stall;

  // State, counter and redirect target registers; reset takes effect at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next-state logic: an exception outranks everything except an ongoing flush.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    if (state_q != FLUSH && excp_valid) begin
      state_d  = FLUSH;
      cnt_d    = '0;
      new_pc_d = excp_eret ? cp0_epc : EXCP_VEC;
    end else begin
      case (state_q)
        IDLE: begin
          // The start cycle itself is the first stall cycle, so BUSY needs
          // cycles-2 further decrements before reaching zero.
          if (ex_mc_start && ex_mc_cycles > CNT_W'(1)) begin
            state_d = BUSY;
            cnt_d   = ex_mc_cycles - CNT_W'(2);
          end else if (ex_mc_start && ex_mc_cycles == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
        BUSY: begin
          // The counter keeps running even while mem holds the pipeline.
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // ex_mc_start here is the finished instruction still presenting.
          if (!mem_stall_req) begin
            state_d = IDLE;
          end
        end
        FLUSH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Stall vector priority: flush, mem, ex multi-cycle, id load-use.
  always_comb begin
    ex_stall = (state_q == BUSY) ||
               (state_q == IDLE && ex_mc_start && ex_mc_cycles != '0);
    stall = 6'b000000;
    if (state_q == FLUSH) begin
      stall = 6'b000000;
    end else if (mem_stall_req) begin
      stall = 6'b011111;
    end else if (ex_stall) begin
      stall = 6'b001111;
    end else if (id_stall_req) begin
      stall = 6'b000111;
    end
  end

  assign flush   = (state_q == FLUSH);
  assign mc_busy = (state_q == BUSY);
  assign mc_done = (state_q == DONE);
  assign new_pc  = new_pc_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline control unit that produces the 6-bit stall vector consumed by every inter-stage register (pc, if/id, id/ex, ex/mem, mem/wb, wb). It arbitrates stall requests from id (load-use), ex (multi-cycle arithmetic) and mem (bus wait). It also generates a one-cycle flush with redirect PC on exception or eret reported by cp0. It contains the multi-cycle ex stall counter, so ex units only issue a start pulse with a cycle count.

Parameters:
EXCP_VEC, 32'h0000_0380, redirect address for exceptions
CNT_W, 6, width of the multi-cycle count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
id_stall_req  input  1  load-use hazard; hold pc and if/id
ex_mc_start  input  1  ex holds a multi-cycle op; level, re-presented while ex is held
ex_mc_cycles  input  CNT_W  total stall cycles for the op; sampled with ex_mc_start in IDLE
mem_stall_req  input  1  memory bus not ready; hold pc through ex/mem
excp_valid  input  1  cp0 commits an exception or eret this cycle
excp_eret  input  1  qualifies excp_valid as eret
cp0_epc  input  32  return address, sampled with excp_valid
stall  output  6  bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb; 1 = hold
flush  output  1  clear all pipeline registers this cycle
new_pc  output  32  redirect target, valid when flush=1
mc_busy  output  1  multi-cycle op in progress
mc_done  output  1  multi-cycle result may be taken this cycle

Behaviour:
- FSM states: IDLE, BUSY, DONE, FLUSH. The counter is CNT_W bits wide.
- On reset: state=IDLE, counter=0, new_pc=0, flush=0, mc_busy=0, mc_done=0. stall is 0 unless request inputs are high.
- stall is combinational from state and inputs. Priority, highest first:
  - state==FLUSH -> 6'b000000.
  - mem_stall_req -> 6'b011111.
  - ex stall (see below) -> 6'b001111.
  - id_stall_req -> 6'b000111.
  - otherwise 6'b000000.
- ex stall is active when:
  - state==BUSY, or
  - state==IDLE and ex_mc_start=1 and ex_mc_cycles!=0.
- flush = (state==FLUSH). mc_busy = (state==BUSY). mc_done = (state==DONE).
- IDLE transitions:
  - If ex_mc_start=1 and ex_mc_cycles>1: counter <= ex_mc_cycles-2, go to BUSY.
  - If ex_mc_start=1 and ex_mc_cycles==1: go to DONE.
  - If ex_mc_cycles==0: treated as a single-cycle op; no stall, no state change.
- BUSY: the counter decrements each cycle. When the counter is 0, go to DONE. The counter runs regardless of mem_stall_req.
- Net effect: ex stall is asserted for exactly ex_mc_cycles consecutive cycles (the start cycle plus N-1 more). mc_done rises in the first cycle after that.
- DONE:
  - ex_mc_start is ignored (it is the same instruction still presenting).
  - Stay in DONE while mem_stall_req=1; otherwise return to IDLE next cycle.
- Any state except FLUSH, with excp_valid=1:
  - Next state is FLUSH. The counter is cleared and any BUSY/DONE op is aborted.
  - new_pc <= excp_eret ? cp0_epc : EXCP_VEC.
- FLUSH lasts exactly one cycle, then goes to IDLE. Inputs are ignored in FLUSH, including excp_valid. new_pc holds its value until the next exception.
- Same-cycle events:
  - excp_valid takes precedence over ex_mc_start.
  - The stall output in the excp_valid cycle still follows the priority list above.
- Reset asserted mid-operation returns immediately to the reset values (asynchronous). It does not wait for a clock edge.

Test Plan:
1. Reset asserted with all requests 0 -> stall=000000, flush=0, new_pc=0, mc_busy=0. Releasing reset with id_stall_req=1 -> stall=000111.
2. ex_mc_start=1, ex_mc_cycles=4, held high -> stall=001111 for exactly 4 cycles, mc_busy=1 in cycles 2-4, mc_done=1 in cycle 5 with stall=000000. Then IDLE.
3. ex_mc_cycles=1 -> one stall cycle, mc_done next cycle. ex_mc_cycles=0 -> no stall, state stays IDLE.
4. During BUSY (ex_mc_cycles=6), raise mem_stall_req in cycle 3 for 5 cycles -> stall=011111 while high. The counter expires underneath, and DONE holds until mem_stall_req drops. Exactly one DONE-exit, with no restart from the held ex_mc_start.
5. excp_valid=1, excp_eret=0 during BUSY -> next cycle flush=1, stall=000000, new_pc=0x380, mc_busy=0. Cycle after: IDLE, flush=0.
6. excp_valid=1, excp_eret=1, cp0_epc=0xBFC0_0100, with id_stall_req=1 and mem_stall_req=1 in the same cycle -> stall=011111 that cycle. Next cycle flush=1, new_pc=0xBFC0_0100. A repeated excp_valid during FLUSH is ignored.
